// File: rtl/ext_int_pkg.sv
// Shared definitions for the external interrupt controller: channel count,
// trigger mode / polarity encodings and the arbiter state type.
package ext_int_pkg;

  localparam int NUM_EINT = 2;

  localparam logic MODE_EDGE  = 1'b1;
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic POL_HIGH   = 1'b1;
  localparam logic POL_LOW    = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/eint_channel.sv
// One external interrupt input: synchronizer, glitch filter, polarity
// selection and rising-edge detection of the active level.
module eint_channel #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ie,
  input  logic mode,
  input  logic pol,
  output logic active,
  output logic rise
);

  localparam logic [3:0] CNT_MAX = 4'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   filt_q;
  logic [3:0]             cnt_q;
  logic                   hist_q;
  logic                   mode_q;
  logic                   pol_q;
  logic                   cfg_chg;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign active   = ~(filt_q ^ pol);
  // A mode or polarity change would look like a fresh edge; suppress it.
  assign cfg_chg  = (mode != mode_q) | (pol != pol_q);
  assign rise     = active & ~hist_q & ~cfg_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      hist_q <= 1'b0;
      mode_q <= 1'b0;
      pol_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ie};
      if (sync_out == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        filt_q <= ~filt_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
      hist_q <= active;
      mode_q <= mode;
      pol_q  <= pol;
    end
  end

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: per-channel pending flags and a fixed
// priority arbiter that raises irq/irq_id toward the CPU.
module ext_int_ctrl
  import ext_int_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_EINT-1:0] ie_in,
  input  logic [NUM_EINT-1:0] eint_en,
  input  logic [NUM_EINT-1:0] eint_mode,
  input  logic [NUM_EINT-1:0] eint_pol,
  input  logic [NUM_EINT-1:0] eint_clr,
  input  logic                irq_ack,
  output logic                irq,
  output logic                irq_id,
  output logic [NUM_EINT-1:0] eint_pend
);

  arb_state_t          state_q;
  logic [NUM_EINT-1:0] active;
  logic [NUM_EINT-1:0] rise;
  logic [NUM_EINT-1:0] pend_q;
  logic [NUM_EINT-1:0] pend_d;
  logic [NUM_EINT-1:0] ack_clr;
  logic [NUM_EINT-1:0] req_vec;

  for (genvar i = 0; i < NUM_EINT; i++) begin : g_ch
    eint_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ie    (ie_in[i]),
      .mode  (eint_mode[i]),
      .pol   (eint_pol[i]),
      .active(active[i]),
      .rise  (rise[i])
    );
  end

  // A new edge wins over a same-cycle software clear or acknowledge.
  always_comb begin
    ack_clr = '0;
    pend_d  = pend_q;
    if (state_q == REQ && irq_ack) ack_clr[irq_id] = 1'b1;
    for (int i = 0; i < NUM_EINT; i++) begin
      if (eint_mode[i] == MODE_EDGE)
        pend_d[i] = rise[i] | (pend_q[i] & ~eint_clr[i] & ~ack_clr[i]);
      else
        pend_d[i] = active[i];
    end
  end

  assign req_vec   = pend_q & eint_en;
  assign eint_pend = pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Channel 0 has priority; irq_id is frozen for the whole request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      irq     <= 1'b0;
      irq_id  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_vec) begin
            state_q <= REQ;
            irq     <= 1'b1;
            irq_id  <= ~req_vec[0];
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_q <= HOLD;
            irq     <= 1'b0;
          end else if (!eint_en[irq_id] || !pend_d[irq_id]) begin
            state_q <= IDLE;
            irq     <= 1'b0;
          end
        end
        HOLD: begin
          state_q <= IDLE;
          irq     <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          irq     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Self-checking bench for ext_int_ctrl: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_ext_int_ctrl;

  localparam int SYNC = 2;
  localparam int FILT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ie_in = '0;
  logic [1:0] eint_en = '0;
  logic [1:0] eint_mode = '0;
  logic [1:0] eint_pol = '0;
  logic [1:0] eint_clr = '0;
  logic       irq_ack = 1'b0;
  logic       irq;
  logic       irq_id;
  logic [1:0] eint_pend;

  int checks = 0;
  int failures = 0;

  // Model: raw samples awaiting synchronization, recent filter inputs,
  // filtered levels, previous active level/config, pending and arbiter.
  logic [1:0] raw_q[$];
  logic [1:0] seen_q[$];
  logic [1:0] m_filt, m_prev_act, m_prev_mode, m_prev_pol, m_pend;
  logic       m_req, m_hold, m_id;

  always #5 clk = ~clk;

  ext_int_ctrl #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ie_in    (ie_in),
    .eint_en  (eint_en),
    .eint_mode(eint_mode),
    .eint_pol (eint_pol),
    .eint_clr (eint_clr),
    .irq_ack  (irq_ack),
    .irq      (irq),
    .irq_id   (irq_id),
    .eint_pend(eint_pend)
  );

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    raw_q.delete();
    seen_q.delete();
    for (int i = 0; i < SYNC; i++) raw_q.push_back(2'b00);
    m_filt = '0; m_prev_act = '0; m_prev_mode = '0; m_prev_pol = '0;
    m_pend = '0; m_req = 1'b0; m_hold = 1'b0; m_id = 1'b0;
  endtask

  // Advance the model by one clock using the inputs the DUT samples.
  task automatic modelStep();
    logic [1:0] act, rse, pnext, s;
    logic       acked, cfg, all_diff;
    acked = m_req && irq_ack;
    for (int ch = 0; ch < 2; ch++) begin
      act[ch] = (m_filt[ch] == eint_pol[ch]);
      cfg = (eint_mode[ch] != m_prev_mode[ch]) || (eint_pol[ch] != m_prev_pol[ch]);
      rse[ch] = act[ch] && !m_prev_act[ch] && !cfg;
      if (eint_mode[ch])
        pnext[ch] = rse[ch] || (m_pend[ch] && !eint_clr[ch] && !(acked && int'(m_id) == ch));
      else
        pnext[ch] = act[ch];
    end
    if (m_req) begin
      if (irq_ack) begin
        m_req = 1'b0;
        m_hold = 1'b1;
      end else if (!eint_en[m_id] || !pnext[m_id]) begin
        m_req = 1'b0;
      end
    end else if (m_hold) begin
      m_hold = 1'b0;
    end else if ((m_pend & eint_en) != 2'b00) begin
      m_req = 1'b1;
      m_id = (m_pend[0] && eint_en[0]) ? 1'b0 : 1'b1;
    end
    s = raw_q.pop_front();
    raw_q.push_back(ie_in);
    seen_q.push_back(s);
    if (seen_q.size() > FILT) void'(seen_q.pop_front());
    for (int ch = 0; ch < 2; ch++) begin
      if (seen_q.size() == FILT) begin
        all_diff = 1'b1;
        foreach (seen_q[j]) if (seen_q[j][ch] == m_filt[ch]) all_diff = 1'b0;
        if (all_diff) m_filt[ch] = ~m_filt[ch];
      end
    end
    m_prev_act = act;
    m_prev_mode = eint_mode;
    m_prev_pol = eint_pol;
    m_pend = pnext;
  endtask

  task automatic checkModel();
    checkOutput("model_irq", {1'b0, irq}, {1'b0, m_req});
    checkOutput("model_irq_id", {1'b0, irq_id}, {1'b0, m_id});
    checkOutput("model_pend", eint_pend, m_pend);
  endtask

  task automatic applyStimulus(input logic [1:0] clr, input logic ack);
    @(negedge clk);
    eint_clr = clr;
    irq_ack = ack;
    @(posedge clk);
    modelStep();
    #1;
    checkModel();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0);
  endtask

  initial begin
    // Reset and reset-state checks
    modelReset();
    #12;
    checkOutput("reset_irq", {1'b0, irq}, 2'b00);
    checkOutput("reset_irq_id", {1'b0, irq_id}, 2'b00);
    checkOutput("reset_pend", eint_pend, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge, rising, channel 0
    eint_en = 2'b01; eint_mode = 2'b11; eint_pol = 2'b11; ie_in = 2'b00;
    idle(4);
    ie_in = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(2'b00, 1'b0);
      if (i == 6) checkOutput("edge_pend_clk6", eint_pend, 2'b00);
      if (i == 7) checkOutput("edge_pend_clk7", eint_pend, 2'b01);
      if (i == 7) checkOutput("edge_irq_clk7", {1'b0, irq}, 2'b00);
      if (i == 8) checkOutput("edge_irq_clk8", {1'b0, irq}, 2'b01);
      if (i == 8) checkOutput("edge_id_clk8", {1'b0, irq_id}, 2'b00);
    end
    applyStimulus(2'b00, 1'b1);
    checkOutput("edge_ack_pend", eint_pend, 2'b00);
    checkOutput("edge_ack_irq", {1'b0, irq}, 2'b00);
    idle(3);
    checkOutput("edge_after_irq", {1'b0, irq}, 2'b00);
    ie_in = 2'b00;
    idle(10);

    // Glitch shorter than the filter on channel 1
    eint_en = 2'b11;
    ie_in = 2'b10;
    idle(3);
    ie_in = 2'b00;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2'b00, 1'b0);
      checkOutput("glitch_irq", {1'b0, irq}, 2'b00);
    end
    checkOutput("glitch_pend", eint_pend, 2'b00);

    // Priority with simultaneous edges
    ie_in = 2'b11;
    idle(8);
    checkOutput("prio_irq", {1'b0, irq}, 2'b01);
    checkOutput("prio_id0", {1'b0, irq_id}, 2'b00);
    applyStimulus(2'b00, 1'b1);
    checkOutput("prio_hold_irq", {1'b0, irq}, 2'b00);
    idle(2);
    checkOutput("prio_rereq_irq", {1'b0, irq}, 2'b01);
    checkOutput("prio_id1", {1'b0, irq_id}, 2'b01);
    applyStimulus(2'b00, 1'b1);
    ie_in = 2'b00;
    idle(10);

    // Level, low polarity, channel 1
    eint_en = 2'b10; eint_mode = 2'b01; eint_pol = 2'b01;
    idle(3);
    checkOutput("lvl_irq", {1'b0, irq}, 2'b01);
    checkOutput("lvl_id", {1'b0, irq_id}, 2'b01);
    applyStimulus(2'b00, 1'b1);
    checkOutput("lvl_ack_irq", {1'b0, irq}, 2'b00);
    checkOutput("lvl_ack_pend", eint_pend, 2'b10);
    idle(2);
    checkOutput("lvl_rereq_irq", {1'b0, irq}, 2'b01);
    ie_in = 2'b10;
    idle(6);
    checkOutput("lvl_pend_clk6", eint_pend, 2'b10);
    idle(1);
    checkOutput("lvl_pend_clk7", eint_pend, 2'b00);
    checkOutput("lvl_drop_irq", {1'b0, irq}, 2'b00);

    // Collision of a new edge with the acknowledge on channel 0
    eint_en = 2'b01; eint_mode = 2'b11; eint_pol = 2'b11; ie_in = 2'b00;
    idle(10);
    ie_in = 2'b01;
    idle(8);
    ie_in = 2'b00;
    idle(8);
    checkOutput("coll_irq_held", {1'b0, irq}, 2'b01);
    ie_in = 2'b01;
    idle(6);
    applyStimulus(2'b00, 1'b1);
    checkOutput("coll_pend", eint_pend, 2'b01);
    checkOutput("coll_hold_irq", {1'b0, irq}, 2'b00);
    idle(2);
    checkOutput("coll_rereq_irq", {1'b0, irq}, 2'b01);
    applyStimulus(2'b00, 1'b1);
    ie_in = 2'b00;
    idle(8);

    // Reset asserted while requesting
    ie_in = 2'b01;
    idle(8);
    checkOutput("rst_pre_irq", {1'b0, irq}, 2'b01);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_irq", {1'b0, irq}, 2'b00);
    checkOutput("rst_async_pend", eint_pend, 2'b00);
    ie_in = 2'b00; eint_clr = 2'b00; irq_ack = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2'b00, 1'b0);
      checkOutput("rst_after_irq", {1'b0, irq}, 2'b00);
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < 2; ch++)
        if ($urandom_range(4, 0) == 0) ie_in[ch] = ~ie_in[ch];
      if ($urandom_range(63, 0) == 0) begin
        eint_en = 2'($urandom);
        eint_mode = 2'($urandom);
        eint_pol = 2'($urandom);
      end
      applyStimulus({($urandom_range(11, 0) == 0), ($urandom_range(11, 0) == 0)},
                    irq ? ($urandom_range(2, 0) == 0) : ($urandom_range(9, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
